instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 16-bit CPU: holds the program counter and fetches 16-bit instruction words from instruction memory over a req/valid handshake.
- Presents each word to the control unit through a valid/ready handshake.
- Consumes the control unit's pc_jump / pc_branch / RAM_adr feedback to select the next PC.
- Stops permanently on a HALT opcode.

Parameters:
- PC_WIDTH, 8: program counter and instruction memory address width; matches the 8-bit RAM_adr field.
- RESET_PC, 0: PC loaded on reset.
- HALT_OPCODE, 4'hF: value of instruction[15:12] that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous reset, active-low (single clock domain; sampled on rising clk).
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  PC_WIDTH  fetch address; equals the current PC.
- mem_rdata  input  16  instruction word from memory.
- mem_valid  input  1  mem_rdata valid; honoured only while mem_req=1.
- instruction  output  16  registered instruction to the control unit. Format: [15:12] opcode, [11:10] reg1, [9:8] reg2, [7:0] RAM_adr / target.
- instr_valid  output  1  instruction is valid.
- instr_ready  input  1  control unit accepts instruction this cycle.
- pc_jump  input  1  control unit: unconditional jump for the current instruction.
- pc_branch  input  1  control unit: taken branch (already qualified by branch_check).
- branch_target  input  PC_WIDTH  jump/branch target (control unit RAM_adr).
- pc  output  PC_WIDTH  address of the instruction currently held or being fetched.
- halted  output  1  HALT instruction retired; fetch stopped.
- issue_count  output  16  number of instructions accepted since reset.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, mem_req=0, mem_addr=RESET_PC, pc=RESET_PC.
  - instruction=16'h0000, instr_valid=0, halted=0, issue_count=0.
  - Reset overrides every other input in the same cycle.
- FSM states: IDLE, FETCH, ISSUE, HALTED.
- IDLE: outputs as reset. Goes to FETCH unconditionally on the next edge with rst_n=1.
- FETCH:
  - mem_req=1; mem_addr=pc, held stable until accepted.
  - On an edge with mem_valid=1: instruction<=mem_rdata, instr_valid<=1, mem_req<=0, go to ISSUE.
  - mem_valid=0: remain in FETCH with no timeout.
- ISSUE:
  - instr_valid=1; instruction and pc held stable until handshake (instr_valid & instr_ready).
  - On the handshake edge, issue_count<=issue_count+1 (wraps at 2^16) and instr_valid<=0.
  - If instruction[15:12]==HALT_OPCODE: go to HALTED; pc unchanged; pc_jump/pc_branch ignored.
  - Else if pc_jump | pc_branch: pc<=branch_target; go to FETCH. Both asserted gives the same result.
  - Else: pc<=pc+1, modulo 2^PC_WIDTH (8'hFF wraps to 8'h00); go to FETCH.
  - pc_jump, pc_branch and branch_target are sampled only on the handshake edge and ignored at all other times.
- HALTED: halted=1, mem_req=0, instr_valid=0. All inputs ignored; leaves only via reset.
- mem_valid while mem_req=0 (IDLE, ISSUE, HALTED) is ignored, including a late response arriving after reset.
- Latency:
  - mem_valid at edge N gives instr_valid=1 from N to N+1.
  - Handshake at edge M gives mem_req=1 with the new mem_addr from M to M+1.
  - With zero-wait memory (mem_valid tied high) and instr_ready tied high, throughput is one instruction per 2 cycles.
- Reset mid-operation (FETCH or ISSUE): mem_req and instr_valid drop at that edge. The pending word is discarded and issue_count clears.
- Control-unit outputs are combinational from instruction, so pc_jump / pc_branch are valid in the ISSUE cycle.

Test Plan:
- Reset then sequential fetch: rst_n low 2 cycles; memory returns 16'h4D00 at addr 0 and 16'h1100 at addr 1, one-cycle latency, instr_ready=1. Required: mem_addr 0 then 1; instruction 16'h4D00 then 16'h1100; issue_count=2; pc=1 while the second word is held.
- Jump redirect: instruction 16'h2C3A at pc=5 with pc_jump=1 and branch_target=8'h3A at handshake. Required: next mem_addr=8'h3A, not 8'h06.
- Branch not taken vs taken: pc=8'h10, pc_branch=0 gives next mem_addr=8'h11. Repeat with pc_branch=1 and target 8'h02: next mem_addr=8'h02.
- Wrap and stall:
  - pc=8'hFF, no redirect: next mem_addr=8'h00.
  - mem_valid held low 4 cycles: mem_req stays 1 and mem_addr stable.
  - instr_ready low 3 cycles: instruction and instr_valid stable, issue_count unchanged.
- HALT: memory returns 16'hF000 at pc=7. Required after handshake: halted=1, mem_req=0, instr_valid=0, pc=7, issue_count incremented once. Further mem_valid and pc_jump pulses have no effect.
- Reset mid-fetch: assert rst_n=0 while in FETCH with mem_req=1, then pulse mem_valid the cycle after release. Required: mem_req=0 during reset, the stale word is not issued, and the first fetch is at RESET_PC with issue_count=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over req/valid, issues over valid/ready.
// One word per two cycles at best; stalls indefinitely on slow memory or a busy control unit.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_valid,
    output logic [15:0]         instruction,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                pc_jump,
    input  logic                pc_branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic [15:0]         issue_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [15:0]         r_instr;
    logic [15:0]         w_instr_nxt;
    logic [15:0]         r_issue_cnt;
    logic [15:0]         w_issue_cnt_nxt;
    logic                w_handshake;

    assign w_handshake = (r_state == S_ISSUE) && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= 16'h0000;
            r_issue_cnt <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_issue_cnt_nxt = r_issue_cnt;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (mem_valid) begin
                    w_instr_nxt = mem_rdata;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_handshake) begin
                    w_issue_cnt_nxt = r_issue_cnt + 16'd1;
                    // HALT wins over any redirect the control unit may present.
                    if (r_instr[15:12] == HALT_OPCODE) begin
                        w_state_nxt = S_HALTED;
                    end else if (pc_jump || pc_branch) begin
                        w_pc_nxt    = branch_target;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_pc_nxt    = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_req     = (r_state == S_FETCH);
    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign instr_valid = (r_state == S_ISSUE);
    assign halted      = (r_state == S_HALTED);
    assign issue_count = r_issue_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory/control-unit responders plus a decoupled monitor.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_valid = 1'b0;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_jump = 1'b0;
    logic        pc_branch = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] issue_count;

    instr_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_jump(pc_jump), .pc_branch(pc_branch), .branch_target(branch_target),
        .pc(pc), .halted(halted), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] word;
        logic        jmp;
        logic        br;
        logic [7:0]  tgt;
        int          smem;
        int          srdy;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem [256];
    int          checks = 0;
    int          failures = 0;
    int          n_pop = 0;
    int          seen = 0;
    int          mwait = 0;
    int          rwait = 0;
    bit          mon_en = 0;
    bit          force_bad = 0;
    bit          force_low = 0;
    bit          force_jmp = 0;
    bit          prev_acc = 0;
    bit          prev_hs = 0;
    bit          prev_halt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [15:0] w, input logic j, input logic b,
                        input logic [7:0] t, input int sm, input int sr);
        exp_t e;
        e.pc = p; e.word = w; e.jmp = j; e.br = b; e.tgt = t; e.smem = sm; e.srdy = sr;
        mem[p] = w;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    // Memory and control-unit responders: inputs change only on the falling edge.
    always @(negedge clk) begin
        if (n_pop != seen) begin
            seen  = n_pop;
            mwait = 0;
            rwait = 0;
        end
        if (force_bad) begin
            mem_valid = 1'b1;
            mem_rdata = 16'hDEAD;
        end else if (force_low) begin
            mem_valid = 1'b0;
            mem_rdata = 16'hBAD0;
        end else begin
            mem_rdata = (mem_req === 1'b1) ? mem[mem_addr] : 16'hBAD0;
            if (mem_req === 1'b1 && q.size() > 0 && mwait < q[0].smem) begin
                mem_valid = 1'b0;
                mwait++;
            end else begin
                mem_valid = 1'b1;
            end
        end
        if (instr_valid === 1'b1 && q.size() > 0 && rwait < q[0].srdy) begin
            instr_ready = 1'b0;
            rwait++;
        end else begin
            instr_ready = 1'b1;
        end
        if (q.size() > 0) begin
            pc_jump       = q[0].jmp;
            pc_branch     = q[0].br;
            branch_target = q[0].tgt;
        end else begin
            pc_jump       = force_jmp;
            pc_branch     = force_jmp;
            branch_target = 8'h3A;
        end
    end

    // Monitor: samples just after the falling edge, pops the scoreboard on each handshake.
    always begin
        @(negedge clk); #1;
        if (!mon_en) begin
            prev_acc  = 0;
            prev_hs   = 0;
            prev_halt = 0;
        end else begin
            if (prev_acc) chk("lat_issue", instr_valid, 1);
            if (prev_hs) chk("lat_fetch", mem_req, 1);
            if (prev_halt) begin
                chk("halted", halted, 1);
                chk("halt_req", mem_req, 0);
                chk("halt_vld", instr_valid, 0);
            end
            prev_acc  = 0;
            prev_hs   = 0;
            prev_halt = 0;
            chk("req_vld_excl", mem_req & instr_valid, 0);
            if (mem_req) begin
                if (q.size() == 0) chk("unexp_req", mem_req, 0);
                else begin
                    chk("fetch_addr", mem_addr, q[0].pc);
                    prev_acc = mem_valid;
                end
            end
            if (instr_valid) begin
                if (q.size() == 0) chk("unexp_vld", instr_valid, 0);
                else begin
                    chk("instr", instruction, q[0].word);
                    chk("pc", pc, q[0].pc);
                    chk("issue_cnt", issue_count, n_pop);
                    if (instr_ready) begin
                        prev_halt = (q[0].word[15:12] == 4'hF);
                        prev_hs   = !prev_halt;
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d pending expected 0", q.size());
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_vld", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", issue_count, 0);

        // pc, word, jump, branch, target, mem stall cycles, ready stall cycles
        push(8'h00, 16'h4D00, 0, 0, 8'h00, 0, 0);
        push(8'h01, 16'h1100, 0, 0, 8'h00, 0, 0);
        push(8'h02, 16'h2C05, 1, 0, 8'h05, 0, 0);
        push(8'h05, 16'h2C3A, 1, 0, 8'h3A, 0, 0);
        push(8'h3A, 16'h2C10, 1, 0, 8'h10, 0, 0);
        push(8'h10, 16'h6002, 0, 0, 8'h02, 0, 0);
        push(8'h11, 16'h2C10, 1, 0, 8'h10, 0, 0);
        push(8'h10, 16'h6002, 0, 1, 8'h02, 0, 0);
        push(8'h02, 16'h2C05, 1, 1, 8'hFF, 0, 0);
        push(8'hFF, 16'h3000, 0, 0, 8'h00, 4, 0);
        push(8'h00, 16'h4D00, 1, 0, 8'h07, 0, 3);
        push(8'h07, 16'hF000, 1, 1, 8'h3A, 0, 0);
        mon_en = 1;
        rst_n  = 1'b1;
        wait_drain("drain_main");

        // Halted: memory responses and jump requests must have no effect.
        force_jmp = 1;
        repeat (3) @(posedge clk);
        #2;
        force_jmp = 0;
        chk("post_halted", halted, 1);
        chk("post_halt_pc", pc, 8'h07);
        chk("post_halt_cnt", issue_count, 12);
        chk("post_halt_req", mem_req, 0);
        chk("post_halt_vld", instr_valid, 0);

        // Reset while a fetch is outstanding, then a stale response right at release.
        mon_en = 0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        force_low = 1;
        for (int n = 0; n < 20 && mem_req !== 1'b1; n++) begin
            @(posedge clk); #2;
        end
        chk("mid_fetch_req", mem_req, 1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_vld", instr_valid, 0);
        chk("mid_rst_cnt", issue_count, 0);
        chk("mid_rst_pc", pc, 8'h00);
        @(posedge clk); #2;
        force_low = 0;
        force_bad = 1;
        n_pop     = 0;
        push(8'h00, 16'h4D00, 0, 0, 8'h00, 0, 0);
        push(8'h01, 16'h1100, 0, 0, 8'h00, 0, 0);
        push(8'h02, 16'h2C05, 1, 0, 8'h07, 0, 0);
        push(8'h07, 16'hF000, 0, 0, 8'h00, 0, 0);
        mon_en = 1;
        rst_n  = 1'b1;
        @(posedge clk); #2;
        force_bad = 0;
        wait_drain("drain_after_rst");
        repeat (2) @(posedge clk);
        #2;
        chk("final_halted", halted, 1);
        chk("final_cnt", issue_count, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
